midi_event_rx: RTL and testbench

Parametrised MIDI front end: receives serial MIDI on `uart_rx`, parses Note On/Note Off messages with running status across all 16 channels, and queues complete note events in a first-word-fall-through FIFO read over a valid/ready handshake. It replaces the single-note `note_on`/`note_off` strobe interface. It sits between the board MIDI input pin and the voice allocator.

---
 rtl/midi_event_rx_if.sv | 15 +
 rtl/midi_event_rx.sv | 180 ++++++++++++++++++
 tb/tb_midi_event_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/midi_event_rx_if.sv
// Note-event stream from the MIDI receiver FIFO to the voice allocator.
// The master presents the FIFO head; the slave pops it with ev_ready.
interface midi_event_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [3:0] ev_channel;
  logic [6:0] ev_note;
  logic [6:0] ev_velocity;

  modport master (output ev_valid, ev_note_on, ev_channel, ev_note, ev_velocity,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_note_on, ev_channel, ev_note, ev_velocity,
                  output ev_ready);
endinterface

// File: rtl/midi_event_rx.sv
// Serial MIDI receiver: UART, Note On/Off parser with running status, and a
// first-word-fall-through FIFO of note events.
module midi_event_rx #(
  parameter int          CLOCK_FREQ   = 100_000_000,
  parameter int          BAUD_RATE    = 31250,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rx,
  midi_event_rx_if.master               ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          framing_error,
  output logic [7:0]                    debug_uart_byte,
  output logic                          debug_uart_ready
);
  localparam int BIT_TICKS  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW         = $clog2(BIT_TICKS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int NW         = AW + 1;

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } note_ev_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2, P_SKIP} p_st_t;

  // ---------------- receiver ----------------
  rx_st_t          rx_st, rx_nxt;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   tick;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_end, half_end;

  assign bit_end  = (tick == CW'(BIT_TICKS - 1));
  assign half_end = (tick == CW'(HALF_TICKS - 1));

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_nxt = RX_START;
      RX_START: if (half_end) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (bit_end) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // Sync flops reset to the idle-high level so reset release is not a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st <= RX_IDLE;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      tick <= '0; bit_idx <= '0; shift <= '0;
      debug_uart_byte <= '0; debug_uart_ready <= 1'b0; framing_error <= 1'b0;
    end else begin
      rx_st <= rx_nxt;
      rx_s1 <= uart_rx; rx_s2 <= rx_s1; rx_prev <= rx_s2;
      debug_uart_ready <= 1'b0;
      framing_error    <= 1'b0;
      case (rx_st)
        RX_START: tick <= half_end ? '0 : tick + 1'b1;
        RX_DATA: begin
          if (bit_end) begin
            tick    <= '0;
            shift   <= {rx_s2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else tick <= tick + 1'b1;
        end
        RX_STOP: begin
          if (bit_end) begin
            tick <= '0;
            if (rx_s2) begin
              debug_uart_byte  <= shift;
              debug_uart_ready <= 1'b1;
            end else framing_error <= 1'b1;
          end else tick <= tick + 1'b1;
        end
        default: begin tick <= '0; bit_idx <= '0; end
      endcase
    end
  end

  // ---------------- parser ----------------
  p_st_t      p_st, p_nxt;
  logic       latch, emit, emit_q;
  logic       rs_on;
  logic [3:0] rs_ch;
  logic [6:0] note_q;
  note_ev_t   ev_q;
  logic [7:0] b;

  assign b = debug_uart_byte;

  always_comb begin
    p_nxt = p_st;
    latch = 1'b0;
    emit  = 1'b0;
    if (debug_uart_ready) begin
      if (b[7]) begin
        if (b[7:3] == 5'b11111) p_nxt = p_st;  // real-time: transparent
        else if (b[7:4] == 4'hF) p_nxt = P_IDLE;
        else if (b[6:5] == 2'b00 && CHANNEL_MASK[b[3:0]]) begin
          p_nxt = P_DATA1;
          latch = 1'b1;
        end else p_nxt = P_SKIP;
      end else begin
        case (p_st)
          P_DATA1: p_nxt = P_DATA2;
          P_DATA2: begin p_nxt = P_DATA1; emit = 1'b1; end
          default: p_nxt = p_st;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_st <= P_IDLE;
      rs_on <= 1'b0; rs_ch <= '0; note_q <= '0;
      emit_q <= 1'b0; ev_q <= '0;
    end else begin
      p_st   <= p_nxt;
      emit_q <= emit;
      if (latch) begin
        rs_on <= b[4];
        rs_ch <= b[3:0];
      end
      if (debug_uart_ready && !b[7] && p_st == P_DATA1) note_q <= b[6:0];
      // Note On with velocity 0 is reported as Note Off.
      if (emit) ev_q <= '{on: rs_on & (|b[6:0]), ch: rs_ch, note: note_q, vel: b[6:0]};
    end
  end

  // ---------------- event FIFO ----------------
  note_ev_t        mem [FIFO_DEPTH];
  note_ev_t        head;
  logic [AW-1:0]   wp, rp, rp_n;
  logic            pop, wr_en;

  assign pop   = ev.ev_valid & ev.ev_ready;
  assign wr_en = emit_q && (fifo_count < NW'(FIFO_DEPTH) || pop);
  assign rp_n  = pop ? rp + 1'b1 : rp;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= ev_q;
  end

  // Head register looks ahead to the post-edge read pointer, bypassing the
  // incoming write when it becomes the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0; rp <= '0; fifo_count <= '0; overflow <= 1'b0; head <= '0;
    end else begin
      rp   <= rp_n;
      head <= (wr_en && wp == rp_n) ? ev_q : mem[rp_n];
      if (wr_en) wp <= wp + 1'b1;
      if (emit_q && !wr_en) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign ev.ev_valid    = (fifo_count != '0);
  assign ev.ev_note_on  = head.on;
  assign ev.ev_channel  = head.ch;
  assign ev.ev_note     = head.note;
  assign ev.ev_velocity = head.vel;
endmodule

// File: tb/tb_midi_event_rx.sv
// Directed bench for midi_event_rx: UART framing, parser, running status,
// channel masking, FIFO overflow and reset abort.
module tb_midi_event_rx;
  localparam int CLOCK_FREQ = 160;
  localparam int BAUD_RATE  = 10;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;
  localparam int DEPTH      = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] fifo_count;
  logic       overflow, framing_error, debug_uart_ready;
  logic [7:0] debug_uart_byte;

  midi_event_rx_if ev ();

  midi_event_rx #(
    .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE),
    .FIFO_DEPTH(DEPTH), .CHANNEL_MASK(16'hFFFB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .ev(ev),
    .fifo_count(fifo_count), .overflow(overflow), .framing_error(framing_error),
    .debug_uart_byte(debug_uart_byte), .debug_uart_ready(debug_uart_ready)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, last_rdy = 0, valid_rise = 0, rdy_cnt = 0, ferr_cnt = 0;
  logic vprev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (debug_uart_ready) begin last_rdy <= cyc; rdy_cnt <= rdy_cnt + 1; end
    if (framing_error) ferr_cnt <= ferr_cnt + 1;
    if (ev.ev_valid && !vprev) valid_rise <= cyc;
    vprev <= ev.ev_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop_ok = 1'b1);
    uart_rx = 1'b0; idle(BIT);
    for (int i = 0; i < 8; i++) begin uart_rx = v[i]; idle(BIT); end
    uart_rx = stop_ok; idle(BIT);
    uart_rx = 1'b1; idle(BIT);
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic pop_check(input string tag, input logic [18:0] exp);
    int n = 0;
    while (!ev.ev_valid && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, ev.ev_valid, 1);
    chk(tag, {ev.ev_note_on, ev.ev_channel, ev.ev_note, ev.ev_velocity}, exp);
    ev.ev_ready = 1'b1; @(negedge clk);
    ev.ev_ready = 1'b0;
  endtask

  function automatic logic [18:0] mk(input logic on, input logic [3:0] ch,
                                     input logic [6:0] nt, input logic [6:0] vl);
    return {on, ch, nt, vl};
  endfunction

  initial begin
    int r0, f0, n;
    ev.ev_ready = 1'b0;
    idle(3);
    chk("rst_valid", ev.ev_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_byte", debug_uart_byte, 0);
    chk("rst_rdy", debug_uart_ready, 0);
    chk("rst_ferr", framing_error, 0);
    reset_n = 1'b1; idle(4);

    // basic note on + latency from last byte to ev_valid
    send_seq('{8'h90, 8'h3C, 8'h7F});
    idle(4);
    chk("lat", valid_rise - last_rdy, 2);
    chk("dbg_byte", debug_uart_byte, 8'h7F);
    chk("cnt1", fifo_count, 1);
    pop_check("ev_basic", mk(1, 0, 7'h3C, 7'h7F));
    idle(2);
    chk("cnt_empty", fifo_count, 0);

    // running status, vel 0 note on, note off
    send_seq('{8'h91, 8'h40, 8'h50, 8'h40, 8'h00, 8'h80, 8'h3C, 8'h00});
    idle(4);
    chk("cnt_rs", fifo_count, 3);
    pop_check("ev_rs0", mk(1, 1, 7'h40, 7'h50));
    pop_check("ev_rs1", mk(0, 1, 7'h40, 7'h00));
    pop_check("ev_rs2", mk(0, 0, 7'h3C, 7'h00));

    // masked channel 2, program change ignored
    send_seq('{8'h92, 8'h30, 8'h10});
    idle(4);
    chk("cnt_mask", fifo_count, 0);
    send_seq('{8'h90, 8'h30, 8'h10, 8'hC0, 8'h05});
    idle(4);
    chk("cnt_unmask", fifo_count, 1);
    pop_check("ev_unmask", mk(1, 0, 7'h30, 7'h10));

    // real-time bytes are transparent; sysex clears running status
    send_seq('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h7F, 8'hF0, 8'h3C, 8'h7F});
    idle(4);
    chk("cnt_rt", fifo_count, 1);
    pop_check("ev_rt", mk(1, 0, 7'h3C, 7'h7F));
    idle(2);
    chk("cnt_sysex", fifo_count, 0);

    // overflow: five events into four entries
    chk("ovf_pre", overflow, 0);
    send_seq('{8'h90, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13,
               8'h04, 8'h14, 8'h05, 8'h15});
    idle(4);
    chk("cnt_full", fifo_count, 4);
    chk("ovf_set", overflow, 1);
    // push and pop in the same cycle while full
    send_byte(8'h06);
    fork
      send_byte(8'h16);
      begin
        n = 0;
        while (!debug_uart_ready && n < 400) begin @(negedge clk); n++; end
        chk("pp_rdy_seen", debug_uart_ready, 1);
        @(negedge clk); ev.ev_ready = 1'b1;
        @(negedge clk); ev.ev_ready = 1'b0;
      end
    join
    chk("cnt_pushpop", fifo_count, 4);
    pop_check("ev_ov0", mk(1, 0, 7'h02, 7'h12));
    pop_check("ev_ov1", mk(1, 0, 7'h03, 7'h13));
    pop_check("ev_ov2", mk(1, 0, 7'h04, 7'h14));
    pop_check("ev_ov3", mk(1, 0, 7'h06, 7'h16));
    idle(2);
    chk("cnt_drained", fifo_count, 0);

    // framing error: stop bit low
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    idle(4);
    chk("ferr_pulses", ferr_cnt - f0, 1);
    chk("ferr_no_rdy", rdy_cnt - r0, 0);

    // reset mid-message and mid-byte
    send_seq('{8'h90, 8'h3C});
    uart_rx = 1'b0; idle(3 * BIT);
    reset_n = 1'b0; #1;
    chk("mid_rst_valid", ev.ev_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_byte", debug_uart_byte, 0);
    chk("mid_rst_rdy", debug_uart_ready, 0);
    uart_rx = 1'b1; idle(3 * BIT);
    reset_n = 1'b1; idle(4);
    send_byte(8'h7F);
    idle(4);
    chk("post_rst_noev", fifo_count, 0);
    send_seq('{8'h95, 8'h20, 8'h30});
    pop_check("ev_post_rst", mk(1, 5, 7'h20, 7'h30));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
